// File: rtl/p_mux_pkg.sv
// Shared constants for the project multiplexer: bus widths, bit-field offsets
// and FSM state encodings.
package p_mux_pkg;

  localparam int unsigned IW_W = 18;
  localparam int unsigned OW_W = 24;

  // Broadcast bus fields: {uio_in, ui_in, rst_n, clk}
  localparam int unsigned IW_CLK   = 0;
  localparam int unsigned IW_RST_N = 1;
  localparam int unsigned IW_UI    = 2;
  localparam int unsigned IW_UIO   = 10;

  // Per-project output fields: {uio_oe, uio_out, uo_out}
  localparam int unsigned OW_UO      = 0;
  localparam int unsigned OW_UIO_OUT = 8;
  localparam int unsigned OW_UIO_OE  = 16;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/p_mux_sync.sv
// Two-flop synchroniser for an asynchronous pad input, with a selectable
// reset level so the output is inactive while the block is in reset.
module p_mux_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/p_mux_ctrl.sv
// Project multiplexer controller: selects one of N_PROJ project wrappers,
// holds the project reset after every selection change, and muxes pad I/O.
module p_mux_ctrl
  import p_mux_pkg::*;
#(
  parameter int unsigned N_PROJ   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RST_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_sel_rst_n,
  input  logic                   ctrl_sel_inc,
  input  logic                   ctrl_ena,
  input  logic                   pad_clk,
  input  logic                   pad_rst_n,
  input  logic [7:0]             pad_ui_in,
  input  logic [7:0]             pad_uio_in,
  output logic [IW_W-1:0]        iw,
  output logic [N_PROJ-1:0]      ena,
  input  logic [OW_W*N_PROJ-1:0] ow_all,
  output logic [7:0]             pad_uo_out,
  output logic [7:0]             pad_uio_out,
  output logic [7:0]             pad_uio_oe,
  output logic [ADDR_W-1:0]      sel_addr,
  output logic                   busy
);

  localparam int unsigned           CNT_W     = $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0]      HOLD_LOAD = CNT_W'(RST_HOLD - 1);
  localparam logic [ADDR_W-1:0]     SEL_MAX   = ADDR_W'(N_PROJ - 1);

  logic sel_rst_n_s, sel_inc_s, ena_s;

  // Synchronisers reset to their inactive level so release causes no events.
  p_mux_sync #(.RST_VAL(1'b1)) u_sync_sel_rst_n (
    .clk(clk), .rst(rst), .d(ctrl_sel_rst_n), .q(sel_rst_n_s)
  );
  p_mux_sync #(.RST_VAL(1'b1)) u_sync_sel_inc (
    .clk(clk), .rst(rst), .d(ctrl_sel_inc), .q(sel_inc_s)
  );
  p_mux_sync #(.RST_VAL(1'b0)) u_sync_ena (
    .clk(clk), .rst(rst), .d(ctrl_ena), .q(ena_s)
  );

  logic              inc_prev_q;
  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [N_PROJ-1:0] ena_q, ena_d;
  logic [OW_W-1:0]   pad_q, pad_d, ow_sel;
  logic              iw_rst_n_q, iw_rst_n_d;
  logic              sel_clr, inc_evt, run_en;

  always_comb begin
    sel_clr = ~sel_rst_n_s;
    inc_evt = sel_inc_s & ~inc_prev_q;
    sel_d   = sel_q;
    if (sel_clr) begin
      sel_d = '0;
    end else if (inc_evt) begin
      sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    if (sel_clr || (sel_d != sel_q)) begin
      state_d = ST_HOLD;
      cnt_d   = HOLD_LOAD;
    end else if (state_q == ST_HOLD) begin
      if (cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    ow_sel = '0;
    for (int unsigned p = 0; p < N_PROJ; p++) begin
      if (sel_d == ADDR_W'(p)) ow_sel = ow_all[p*OW_W +: OW_W];
    end
  end

  // Outputs are computed from next state so they line up with busy.
  always_comb begin
    run_en = (state_d == ST_RUN) && ena_s;
    ena_d  = '0;
    if (run_en) ena_d[sel_d] = 1'b1;
    pad_d      = run_en ? ow_sel : '0;
    iw_rst_n_d = pad_rst_n && (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_prev_q <= 1'b1;
      state_q    <= ST_HOLD;
      cnt_q      <= HOLD_LOAD;
      sel_q      <= '0;
      ena_q      <= '0;
      pad_q      <= '0;
      iw_rst_n_q <= 1'b0;
    end else begin
      inc_prev_q <= sel_inc_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      ena_q      <= ena_d;
      pad_q      <= pad_d;
      iw_rst_n_q <= iw_rst_n_d;
    end
  end

  assign iw[IW_CLK]       = pad_clk;
  assign iw[IW_RST_N]     = iw_rst_n_q;
  assign iw[IW_UI +: 8]   = pad_ui_in;
  assign iw[IW_UIO +: 8]  = pad_uio_in;
  assign ena              = ena_q;
  assign pad_uo_out       = pad_q[OW_UO +: 8];
  assign pad_uio_out      = pad_q[OW_UIO_OUT +: 8];
  assign pad_uio_oe       = pad_q[OW_UIO_OE +: 8];
  assign sel_addr         = sel_q;
  assign busy             = (state_q == ST_HOLD);

endmodule

// File: tb/tb_p_mux_ctrl.sv
// Self-checking bench for p_mux_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the selection rules.
module tb_p_mux_ctrl;

  localparam int N_PROJ   = 16;
  localparam int ADDR_W   = 4;
  localparam int RST_HOLD = 8;

  logic                 clk = 1'b0;
  logic                 rst, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
  logic                 pad_clk, pad_rst_n;
  logic [7:0]           pad_ui_in, pad_uio_in;
  logic [17:0]          iw;
  logic [N_PROJ-1:0]    ena;
  logic [24*N_PROJ-1:0] ow_all;
  logic [7:0]           pad_uo_out, pad_uio_out, pad_uio_oe;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  p_mux_ctrl #(.N_PROJ(N_PROJ), .ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_ena(ctrl_ena), .pad_clk(pad_clk), .pad_rst_n(pad_rst_n), .pad_ui_in(pad_ui_in),
    .pad_uio_in(pad_uio_in), .iw(iw), .ena(ena), .ow_all(ow_all), .pad_uo_out(pad_uo_out),
    .pad_uio_out(pad_uio_out), .pad_uio_oe(pad_uio_oe), .sel_addr(sel_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: synchronised inputs are the pad values seen two edges earlier;
  // busy lasts until RST_HOLD edges after the most recent change event.
  int          k = 0, hold_end = 0, msel = 0;
  bit          ih0, ih1, iprev, rh0, rh1, eh0, eh1;
  bit          m_busy, m_iw1;
  logic [15:0] m_ena;
  logic [23:0] m_ow;

  task automatic step();
    bit clr, ev, en_use, run;
    int nsel;
    @(posedge clk);
    k++;
    if (rst) begin
      ih0 = 1; ih1 = 1; iprev = 1; rh0 = 1; rh1 = 1; eh0 = 0; eh1 = 0;
      msel = 0; hold_end = k + RST_HOLD;
      m_busy = 1; m_ena = '0; m_ow = '0; m_iw1 = 0;
    end else begin
      clr = !rh1; ev = ih1 && !iprev; en_use = eh1;
      nsel = clr ? 0 : (ev ? (msel + 1) % N_PROJ : msel);
      if (clr || nsel != msel) hold_end = k + RST_HOLD;
      msel = nsel; iprev = ih1;
      ih1 = ih0; ih0 = ctrl_sel_inc; rh1 = rh0; rh0 = ctrl_sel_rst_n; eh1 = eh0; eh0 = ctrl_ena;
      m_busy = (k < hold_end);
      run    = !m_busy && en_use;
      m_ena  = run ? (16'h1 << msel) : 16'h0;
      m_ow   = run ? ow_all[24*msel +: 24] : 24'h0;
      m_iw1  = pad_rst_n && !m_busy;
    end
    #1;
  endtask

  task automatic randomize_data();
    pad_clk    = 1'($urandom);
    pad_ui_in  = 8'($urandom);
    pad_uio_in = 8'($urandom);
    for (int p = 0; p < N_PROJ; p++) ow_all[p*24 +: 24] = 24'($urandom);
  endtask

  task automatic test_reset();
    rst = 1; ctrl_sel_rst_n = 1; ctrl_sel_inc = 0; ctrl_ena = 1; pad_rst_n = 1;
    randomize_data();
    repeat (3) step();
    n_checks++;
    if ({sel_addr, busy, ena, pad_uo_out, pad_uio_out, pad_uio_oe, iw[1]} !==
        {4'd0, 1'b1, 16'h0, 24'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got sel=%0d busy=%b ena=%h uo=%h iw1=%b, want 0/1/0/0/0",
               sel_addr, busy, ena, pad_uo_out, iw[1]);
    end
    rst = 0;
    for (int i = 1; i <= RST_HOLD; i++) begin
      step();
      if (i < RST_HOLD) begin
        n_checks++;
        if (busy !== 1'b1 || ena !== 16'h0) begin
          n_fail++;
          $display("FAIL reset_hold[%0d]: got busy=%b ena=%h, want busy=1 ena=0000", i, busy, ena);
        end
      end
    end
    n_checks++;
    if (busy !== 1'b0 || ena !== 16'h0001 || iw[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b ena=%h iw1=%b, want 0/0001/1", busy, ena, iw[1]);
    end
    pad_rst_n = 0;
    step();
    n_checks++;
    if (iw[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL iw_rst_n_low: got %b want 0", iw[1]);
    end
    pad_rst_n = 1;
    step();
    n_checks++;
    if (iw !== {pad_uio_in, pad_ui_in, 1'b1, pad_clk}) begin
      n_fail++;
      $display("FAIL iw_passthrough: got %h want %h", iw, {pad_uio_in, pad_ui_in, 1'b1, pad_clk});
    end
  endtask

  task automatic test_increment();
    for (int i = 0; i < 3; i++) begin
      ctrl_sel_inc = 1; repeat (3) step();
      ctrl_sel_inc = 0; repeat (3) step();
    end
    repeat (RST_HOLD + 2) step();
    n_checks++;
    if (sel_addr !== 4'd3 || ena !== 16'h0008 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL three_incs: got sel=%0d ena=%h busy=%b, want 3/0008/0", sel_addr, ena, busy);
    end
    for (int i = 0; i < 4; i++) begin
      randomize_data();
      step();
      n_checks++;
      if ({pad_uio_oe, pad_uio_out, pad_uo_out} !== ow_all[95:72]) begin
        n_fail++;
        $display("FAIL proj3_outputs: got %h want %h", {pad_uio_oe, pad_uio_out, pad_uo_out},
                 ow_all[95:72]);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < N_PROJ && msel != N_PROJ - 1; i++) begin
      ctrl_sel_inc = 1; repeat (3) step();
      ctrl_sel_inc = 0; repeat (3) step();
    end
    repeat (RST_HOLD + 2) step();
    n_checks++;
    if (sel_addr !== 4'd15 || ena !== 16'h8000) begin
      n_fail++;
      $display("FAIL reach_15: got sel=%0d ena=%h, want 15/8000", sel_addr, ena);
    end
    ctrl_sel_inc = 1;
    repeat (3) step();
    ctrl_sel_inc = 0;
    n_checks++;
    if (sel_addr !== 4'd0 || busy !== 1'b1 || ena !== 16'h0) begin
      n_fail++;
      $display("FAIL wrap: got sel=%0d busy=%b ena=%h, want 0/1/0000", sel_addr, busy, ena);
    end
    for (int i = 1; i <= RST_HOLD; i++) begin
      step();
      n_checks++;
      if (busy !== (i < RST_HOLD)) begin
        n_fail++;
        $display("FAIL wrap_hold[%0d]: got busy=%b want %b", i, busy, i < RST_HOLD);
      end
    end
    n_checks++;
    if (ena !== 16'h0001) begin
      n_fail++;
      $display("FAIL wrap_ena: got %h want 0001", ena);
    end
  endtask

  task automatic test_simultaneous();
    ctrl_sel_inc = 1; ctrl_sel_rst_n = 0;
    repeat (3) step();
    n_checks++;
    if (sel_addr !== 4'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_beats_inc: got sel=%0d busy=%b, want 0/1", sel_addr, busy);
    end
    ctrl_sel_inc = 0; ctrl_sel_rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      if (hold_end - k == 6) break;
      step();
    end
    // Increment lands on the edge where the hold counter reads 3.
    ctrl_sel_inc = 1;
    repeat (3) step();
    ctrl_sel_inc = 0;
    n_checks++;
    if (sel_addr !== 4'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_inc: got sel=%0d busy=%b, want 1/1", sel_addr, busy);
    end
    repeat (RST_HOLD - 1) step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_extends: got busy=%b want 1", busy);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || ena !== 16'h0002) begin
      n_fail++;
      $display("FAIL restart_end: got busy=%b ena=%h, want 0/0002", busy, ena);
    end
  endtask

  task automatic test_enable_off();
    ctrl_ena = 0;
    repeat (2) step();
    n_checks++;
    if (ena !== 16'h0002) begin
      n_fail++;
      $display("FAIL ena_sync_delay: got %h want 0002", ena);
    end
    step();
    n_checks++;
    if (ena !== 16'h0 || {pad_uio_oe, pad_uio_out, pad_uo_out} !== 24'h0 || sel_addr !== 4'd1
        || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ena_off: got ena=%h pads=%h sel=%0d busy=%b, want 0/0/1/0", ena,
               {pad_uio_oe, pad_uio_out, pad_uo_out}, sel_addr, busy);
    end
    ctrl_ena = 1;
    repeat (3) step();
    n_checks++;
    if (ena !== 16'h0002 || {pad_uio_oe, pad_uio_out, pad_uo_out} !== ow_all[47:24]) begin
      n_fail++;
      $display("FAIL ena_on: got ena=%h pads=%h, want 0002/%h", ena,
               {pad_uio_oe, pad_uio_out, pad_uo_out}, ow_all[47:24]);
    end
  endtask

  task automatic test_mid_hold_reset();
    ctrl_sel_inc = 1;
    repeat (5) step();
    rst = 1;
    step();
    n_checks++;
    if ({sel_addr, busy, ena, pad_uo_out, pad_uio_out, pad_uio_oe, iw[1]} !==
        {4'd0, 1'b1, 16'h0, 24'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_hold_rst: got sel=%0d busy=%b ena=%h iw1=%b, want 0/1/0/0",
               sel_addr, busy, ena, iw[1]);
    end
    rst = 0;
    repeat (RST_HOLD) step();
    n_checks++;
    if (sel_addr !== 4'd0 || busy !== 1'b0 || ena !== 16'h0001) begin
      n_fail++;
      $display("FAIL rst_release_no_inc: got sel=%0d busy=%b ena=%h, want 0/0/0001",
               sel_addr, busy, ena);
    end
    ctrl_sel_inc = 0;
    repeat (3) step();
  endtask

  task automatic test_random();
    logic [58:0] got, exp;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) ctrl_sel_inc = ~ctrl_sel_inc;
      ctrl_sel_rst_n = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 50) == 0) ctrl_ena = ~ctrl_ena;
      rst = ($urandom_range(0, 150) == 0);
      pad_rst_n = ($urandom_range(0, 5) != 0);
      randomize_data();
      step();
      got = {sel_addr, busy, ena, pad_uio_oe, pad_uio_out, pad_uo_out, iw[1]};
      exp = {4'(msel), m_busy, m_ena, m_ow, m_iw1};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_wrap();
    test_simultaneous();
    test_enable_off();
    test_mid_hold_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
